// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared types, constants and the tick-divider helper for uart_rx.
// Revision: 1.0 - initial release
// ============================================================================
package uart_pkg;

   localparam int DATA_BITS      = 8;
   localparam int OVERSAMPLE_DEF = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } rx_state_t;

   // Integer truncation: the residual baud error is absorbed by the
   // per-start-bit phase realignment.
   function automatic int calc_os_div(input int clock_freq, input int baud_rate,
                                      input int oversample);
      return clock_freq / (baud_rate * oversample);
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_if
// Brief   : Byte delivery and status bundle between uart_rx and its consumer.
//           parity_err exists only when UART_RX_PARITY_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
interface uart_rx_if;
   import uart_pkg::*;

   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 rx_ready;
   logic                 frame_err;
   logic                 overrun;
`ifdef UART_RX_PARITY_EN
   logic                 parity_err;
`endif

   modport master (
      input  rx_ready,
      output rx_data, rx_valid, frame_err, overrun
`ifdef UART_RX_PARITY_EN
      , parity_err
`endif
   );

   modport slave (
      output rx_ready,
      input  rx_data, rx_valid, frame_err, overrun
`ifdef UART_RX_PARITY_EN
      , parity_err
`endif
   );

endinterface
`default_nettype wire

// File: rtl/uart_rx_tick_gen.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_tick_gen
// Brief   : Oversample tick divider (0..DIV-1) with synchronous restart.
// Revision: 1.0 - initial release
// ============================================================================
module uart_rx_tick_gen #(
   parameter int DIV = 325
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   output logic os_tick
);

   localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n || restart) begin
         r_cnt <= '0;
      end else if (r_cnt == LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign os_tick = (r_cnt == LAST);

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx
// Brief   : 8N1 UART receiver, 16x oversampled, valid/ready holding register.
//           Define UART_RX_PARITY_EN for an even-parity bit and parity_err.
// Revision: 1.0 - initial release
// ============================================================================
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLOCK_FREQ = 50000000,
   parameter int BAUD_RATE  = 9600,
   parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     rx,
   uart_rx_if.master bus
);

   localparam int             OS_DIV      = calc_os_div(CLOCK_FREQ, BAUD_RATE, OVERSAMPLE);
   localparam int             SCW         = $clog2(OVERSAMPLE);
   localparam logic [SCW-1:0] SAMPLE_LAST = SCW'(OVERSAMPLE - 1);
   localparam logic [SCW-1:0] SAMPLE_MID  = SCW'(OVERSAMPLE / 2 - 1);
   localparam logic [2:0]     LAST_BIT    = 3'(DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
   localparam rx_state_t      AFTER_DATA  = PARITY;
`else
   localparam rx_state_t      AFTER_DATA  = STOP;
`endif

   logic                 r_rx_meta;
   logic                 r_rx_s;
   logic                 r_rx_s_d;
   rx_state_t            r_state;
   logic [SCW-1:0]       r_sample_cnt;
   logic [2:0]           r_bit_idx;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] r_rx_data;
   logic                 r_rx_valid;
   logic                 r_frame_err;
   logic                 r_overrun;
`ifdef UART_RX_PARITY_EN
   logic                 r_parity_bit;
   logic                 r_parity_err;
`endif

   logic w_start_edge;
   logic w_os_tick;
   logic w_mid;
   logic w_parity_ok;

   assign w_start_edge = (r_state == IDLE) && r_rx_s_d && !r_rx_s;
   assign w_mid        = w_os_tick && (r_sample_cnt == SAMPLE_MID);
`ifdef UART_RX_PARITY_EN
   assign w_parity_ok  = ~(^{r_shift, r_parity_bit});
`else
   assign w_parity_ok  = 1'b1;
`endif

   uart_rx_tick_gen #(
      .DIV (OS_DIV)
   ) u_tick_gen (
      .clk     (clk),
      .rst_n   (rst_n),
      .restart (w_start_edge),
      .os_tick (w_os_tick)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rx_meta    <= 1'b1;
         r_rx_s       <= 1'b1;
         r_rx_s_d     <= 1'b1;
         r_state      <= IDLE;
         r_sample_cnt <= '0;
         r_bit_idx    <= '0;
         r_shift      <= '0;
         r_rx_data    <= '0;
         r_rx_valid   <= 1'b0;
         r_frame_err  <= 1'b0;
         r_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_parity_bit <= 1'b0;
         r_parity_err <= 1'b0;
`endif
      end else begin
         r_rx_meta   <= rx;
         r_rx_s      <= r_rx_meta;
         r_rx_s_d    <= r_rx_s;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_parity_err <= 1'b0;
`endif

         if (r_rx_valid && bus.rx_ready) begin
            r_rx_valid <= 1'b0;
         end

         // The sample counter keeps free-running mod OVERSAMPLE across the
         // frame, so every mid-bit decision lands on the same count.
         if (w_start_edge) begin
            r_sample_cnt <= '0;
         end else if (w_os_tick && (r_state != IDLE)) begin
            r_sample_cnt <= (r_sample_cnt == SAMPLE_LAST) ? '0 : r_sample_cnt + 1'b1;
         end

         case (r_state)
            IDLE: begin
               if (w_start_edge) begin
                  r_state <= START;
               end
            end
            START: begin
               if (w_mid) begin
                  if (!r_rx_s) begin
                     r_state   <= DATA;
                     r_bit_idx <= '0;
                  end else begin
                     r_state   <= IDLE;
                  end
               end
            end
            DATA: begin
               if (w_mid) begin
                  r_shift[r_bit_idx] <= r_rx_s;
                  if (r_bit_idx == LAST_BIT) begin
                     r_state <= AFTER_DATA;
                  end else begin
                     r_bit_idx <= r_bit_idx + 3'd1;
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (w_mid) begin
                  r_parity_bit <= r_rx_s;
                  r_state      <= STOP;
               end
            end
`endif
            STOP: begin
               if (w_mid) begin
                  r_state <= IDLE;
                  if (!r_rx_s) begin
                     r_frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                  end else if (!w_parity_ok) begin
                     r_parity_err <= 1'b1;
`endif
                  end else if (r_rx_valid && !bus.rx_ready) begin
                     r_overrun <= 1'b1;
                  end else if (w_parity_ok) begin
                     // Covers the accept-and-load case: rx_valid stays high.
                     r_rx_data  <= r_shift;
                     r_rx_valid <= 1'b1;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.rx_data   = r_rx_data;
   assign bus.rx_valid  = r_rx_valid;
   assign bus.frame_err = r_frame_err;
   assign bus.overrun   = r_overrun;
`ifdef UART_RX_PARITY_EN
   assign bus.parity_err = r_parity_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_rx
// Brief   : Self-checking bench for uart_rx at 1.6 MHz / 10 kBd (160 clk/bit).
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_rx;

   localparam int CLK_PER_BIT = 160;
`ifdef UART_RX_PARITY_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif
   // rx -> rx_s takes 2 clocks, then 1521 clocks to the registered result.
   localparam int EVENT_LAT = 2 + 1521 + PAR_BITS * CLK_PER_BIT;

   typedef enum int {EV_GOOD, EV_FRAME, EV_PARITY} ev_kind_t;
   typedef struct {
      int         at;
      ev_kind_t   kind;
      logic [7:0] data;
   } ev_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic rx    = 1'b1;

   uart_rx_if bus ();

   uart_rx #(
      .CLOCK_FREQ (1600000),
      .BAUD_RATE  (10000),
      .OVERSAMPLE (16)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .rx    (rx),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   ev_t        evq[$];
   logic       exp_valid = 1'b0;
   logic [7:0] exp_data  = 8'h00;
   logic       exp_fe    = 1'b0;
   logic       exp_ov    = 1'b0;
   logic       exp_pe    = 1'b0;

   int         n_rise = 0, n_fe = 0, n_ov = 0, n_pe = 0;
   int         last_rise_cyc = 0;
   logic [7:0] rise_data = 8'h00;
   logic       prev_valid = 1'b0;

   // Model: frames become scheduled outcomes; the holding register follows
   // the accept / load / overrun rules at each clock edge.
   initial begin
      ev_t ev;
      forever begin
         @(posedge clk);
         cyc    = cyc + 1;
         exp_fe = 1'b0;
         exp_ov = 1'b0;
         exp_pe = 1'b0;
         if (!rst_n) begin
            exp_valid = 1'b0;
            exp_data  = 8'h00;
            evq.delete();
         end else begin
            if (exp_valid && bus.rx_ready) exp_valid = 1'b0;
            if (evq.size() > 0 && evq[0].at == cyc) begin
               ev = evq.pop_front();
               case (ev.kind)
                  EV_FRAME:  exp_fe = 1'b1;
                  EV_PARITY: exp_pe = 1'b1;
                  default: begin
                     if (exp_valid) exp_ov = 1'b1;
                     else begin
                        exp_valid = 1'b1;
                        exp_data  = ev.data;
                     end
                  end
               endcase
            end
         end
      end
   end

   // Per-cycle compare plus pulse/rise monitor.
   initial begin
      logic [11:0] act, exp;
      logic        act_pe;
      forever begin
         @(negedge clk);
`ifdef UART_RX_PARITY_EN
         act_pe = bus.parity_err;
`else
         act_pe = 1'b0;
`endif
         act = {bus.rx_valid, bus.frame_err, bus.overrun, act_pe,
                bus.rx_valid ? bus.rx_data : 8'h00};
         exp = {exp_valid, exp_fe, exp_ov, exp_pe, exp_valid ? exp_data : 8'h00};
         checks = checks + 1;
         if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL cycle_cmp cyc=%0d got=%h expected=%h", cyc, act, exp);
         end
         if (bus.rx_valid && !prev_valid) begin
            n_rise        = n_rise + 1;
            last_rise_cyc = cyc;
            rise_data     = bus.rx_data;
         end
         prev_valid = bus.rx_valid;
         if (bus.frame_err) n_fe = n_fe + 1;
         if (bus.overrun)   n_ov = n_ov + 1;
         if (act_pe)        n_pe = n_pe + 1;
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks = checks + 1;
      if (got !== want) begin
         failures = failures + 1;
         $display("FAIL %s got=%0h expected=%0h", name, got, want);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drives one frame on negedges; abort_bit >= 0 pulses rst_n during that
   // data bit and leaves the line idle.
   task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                             input logic par_bit, input int abort_bit, output int t0);
      ev_t ev;
      @(negedge clk);
      rx = 1'b0;
      t0 = cyc;
      if (abort_bit < 0) begin
         ev.at   = t0 + EVENT_LAT;
         ev.data = data;
         if (!stop_bit)                              ev.kind = EV_FRAME;
         else if (PAR_BITS == 1 && ((^data) ^ par_bit)) ev.kind = EV_PARITY;
         else                                        ev.kind = EV_GOOD;
         evq.push_back(ev);
      end
      idle(CLK_PER_BIT);
      for (int i = 0; i < 8; i++) begin
         rx = data[i];
         if (i == abort_bit) begin
            idle(40);
            rst_n = 1'b0;
            idle(2);
            rst_n = 1'b1;
            rx    = 1'b1;
            return;
         end
         idle(CLK_PER_BIT);
      end
      if (PAR_BITS == 1) begin
         rx = par_bit;
         idle(CLK_PER_BIT);
      end
      rx = stop_bit;
      idle(CLK_PER_BIT);
      rx = 1'b1;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL timeout cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int t, r0, f0, o0, p0;
      bus.rx_ready = 1'b1;
      rst_n        = 1'b0;
      rx           = 1'b1;
      idle(3);
      check("reset_outputs", 32'({bus.rx_valid, bus.frame_err, bus.overrun, bus.rx_data}), 0);
      rst_n = 1'b1;
      idle(20);

      // 0xA5, consumer always ready
      r0 = n_rise; f0 = n_fe;
      send_frame(8'hA5, 1'b1, 1'b0, -1, t);
      idle(100);
`ifdef UART_RX_PARITY_EN
      check("a5_latency", 32'(last_rise_cyc - t), 1683);
`else
      check("a5_latency", 32'(last_rise_cyc - t), 1523);
`endif
      check("a5_data", 32'(rise_data), 'hA5);
      check("a5_valid_once", 32'(n_rise - r0), 1);
      check("a5_no_frame_err", 32'(n_fe - f0), 0);
      check("a5_valid_dropped", 32'(bus.rx_valid), 0);

      // 0x00 then 0xFF back-to-back with consumer stalled
      bus.rx_ready = 1'b0;
      o0 = n_ov;
      send_frame(8'h00, 1'b1, 1'b0, -1, t);
      send_frame(8'hFF, 1'b1, 1'b0, -1, t);
      idle(100);
      check("overrun_once", 32'(n_ov - o0), 1);
      check("overrun_hold", 32'({bus.rx_valid, bus.rx_data}), 'h100);
      bus.rx_ready = 1'b1;
      idle(1);
      check("accept_clears", 32'(bus.rx_valid), 0);

      // 0x3C with bad stop bit, then a good 0x3C
      r0 = n_rise; f0 = n_fe;
      send_frame(8'h3C, 1'b0, 1'b0, -1, t);
      idle(200);
      check("frame_err_once", 32'(n_fe - f0), 1);
      check("frame_err_no_valid", 32'(n_rise - r0), 0);
      send_frame(8'h3C, 1'b1, 1'b0, -1, t);
      idle(100);
      check("after_fe_data", 32'(rise_data), 'h3C);
      check("after_fe_valid", 32'(n_rise - r0), 1);

      // 40-clock low glitch on an idle line
      r0 = n_rise; f0 = n_fe; o0 = n_ov;
      @(negedge clk);
      rx = 1'b0;
      idle(40);
      rx = 1'b1;
      idle(2000);
      check("glitch_quiet", 32'((n_rise - r0) + (n_fe - f0) + (n_ov - o0)), 0);

      // Hold 0x11, then reset during bit 4 of 0x55
      bus.rx_ready = 1'b0;
      send_frame(8'h11, 1'b1, 1'b0, -1, t);
      idle(100);
      check("hold_11", 32'({bus.rx_valid, bus.rx_data}), 'h111);
      send_frame(8'h55, 1'b1, 1'b0, 4, t);
      check("reset_midframe_outputs",
            32'({bus.rx_valid, bus.frame_err, bus.overrun, bus.rx_data}), 0);
      r0 = n_rise; f0 = n_fe; o0 = n_ov;
      idle(2000);
      check("reset_midframe_quiet", 32'((n_rise - r0) + (n_fe - f0) + (n_ov - o0)), 0);
      bus.rx_ready = 1'b1;
      send_frame(8'h55, 1'b1, 1'b0, -1, t);
      idle(100);
      check("after_reset_data", 32'(rise_data), 'h55);
      check("after_reset_valid", 32'(n_rise - r0), 1);

`ifdef UART_RX_PARITY_EN
      // 0x07 has three ones: even parity needs parity bit 1
      r0 = n_rise; p0 = n_pe;
      send_frame(8'h07, 1'b1, 1'b0, -1, t);
      idle(100);
      check("parity_err_once", 32'(n_pe - p0), 1);
      check("parity_err_no_valid", 32'(n_rise - r0), 0);
      bus.rx_ready = 1'b0;
      send_frame(8'h07, 1'b1, 1'b1, -1, t);
      idle(100);
      check("parity_ok_hold", 32'({bus.rx_valid, bus.rx_data}), 'h107);
      bus.rx_ready = 1'b1;
      idle(5);
`else
      p0 = n_pe;
      check("no_parity_pulses", 32'(n_pe - p0), 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
